// File: rtl/pe_namespace_loader_pkg.sv
// Shared types for the PE namespace loader: header layout, namespace
// encodings, FSM states and the instruction-phase helper.
package pe_namespace_loader_pkg;

    localparam int LOG_NUM_PE   = 3;
    localparam int NUM_PE       = 1 << LOG_NUM_PE;
    localparam int LOG_MEM_NS   = 2;
    localparam int MEM_DATA_LEN = 16;
    localparam int COUNT_LEN    = 11;
    localparam int INST_WORDS   = 5;
    localparam int PHASE_W      = $clog2(INST_WORDS);
    localparam int WORD_CNT_W   = 16;

    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_TYPE_LSB = HDR_LEN_LSB + COUNT_LEN;
    localparam int HDR_PE_LSB   = HDR_TYPE_LSB + LOG_MEM_NS;

    typedef logic [LOG_NUM_PE-1:0]   pe_id_t;
    typedef logic [COUNT_LEN-1:0]    len_t;
    typedef logic [MEM_DATA_LEN-1:0] word_t;
    typedef logic [PHASE_W-1:0]      phase_t;

    typedef enum logic [LOG_MEM_NS-1:0] {
        NS_INST   = 2'd0,
        NS_DATA   = 2'd1,
        NS_WEIGHT = 2'd2,
        NS_META   = 2'd3
    } ns_type_e;

    // Field order mirrors the header word: [15:13] pe, [12:11] type, [10:0] len-1
    typedef struct packed {
        pe_id_t   pe;
        ns_type_e ns;
        len_t     len_m1;
    } hdr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BURST,
        S_SYNC,
        S_START,
        S_RUN,
        S_DONE
    } state_e;

    localparam phase_t INST_LAST = phase_t'(INST_WORDS - 1);

    function automatic phase_t phase_inc(input phase_t p);
        return (p == INST_LAST) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/pe_namespace_loader_if.sv
// Host stream input and shared namespace write bus of the loader.
interface pe_namespace_loader_if;
    import pe_namespace_loader_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    word_t                 in_data;
    logic                  in_last;

    logic                  mem_wrt_back;
    logic                  mem_wrt_valid;
    logic [LOG_NUM_PE-1:0] peId_mem_in;
    logic [LOG_MEM_NS-1:0] mem_data_type;
    word_t                 mem_data_out;

    modport master (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  mem_wrt_back,
        output in_ready,
        output mem_wrt_valid,
        output peId_mem_in,
        output mem_data_type,
        output mem_data_out
    );

    modport slave (
        output in_valid,
        output in_data,
        output in_last,
        output mem_wrt_back,
        input  in_ready,
        input  mem_wrt_valid,
        input  peId_mem_in,
        input  mem_data_type,
        input  mem_data_out
    );

endinterface

// File: rtl/pe_namespace_loader.sv
// Parses header/payload bursts onto the PE namespace write bus, then
// waits for all PEs, pulses start, and reports completion.
module pe_namespace_loader
    import pe_namespace_loader_pkg::*;
(
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cfg_go,
    input  logic                  cfg_abort,
    input  logic [NUM_PE-1:0]     pe_wrt_done,
    input  logic [NUM_PE-1:0]     pe_eoc,
    output logic                  start,
    output logic                  done,
    output logic                  busy,
    output logic                  err_inst_align,
    output logic [WORD_CNT_W-1:0] word_cnt,
    pe_namespace_loader_if.master bus
);

    state_e   state;
    pe_id_t   pe_q;
    ns_type_e ns_q;
    logic     last_q;
    len_t     remaining;
    phase_t   phase;

    logic     wr_valid;
    pe_id_t   wr_pe;
    ns_type_e wr_ns;
    word_t    wr_data;

    logic     accept;
    logic     hs;
    logic     burst_end;
    hdr_t     hdr_in;

    assign accept    = (state == S_HDR) || (state == S_BURST);
    assign hs        = bus.in_valid && bus.in_ready;
    assign burst_end = (remaining == '0);
    assign hdr_in    = hdr_t'(bus.in_data);

    // Write-back owns the bus: stall the stream in the same cycle
    assign bus.in_ready      = accept && !bus.mem_wrt_back;
    assign bus.mem_wrt_valid = wr_valid;
    assign bus.peId_mem_in   = wr_pe;
    assign bus.mem_data_type = wr_ns;
    assign bus.mem_data_out  = wr_data;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state          <= S_IDLE;
            pe_q           <= '0;
            ns_q           <= NS_INST;
            last_q         <= 1'b0;
            remaining      <= '0;
            phase          <= '0;
            wr_valid       <= 1'b0;
            wr_pe          <= '0;
            wr_ns          <= NS_INST;
            wr_data        <= '0;
            start          <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            err_inst_align <= 1'b0;
            word_cnt       <= '0;
        end else if (cfg_abort) begin
            state    <= S_IDLE;
            wr_valid <= 1'b0;
            start    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            start    <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cfg_go) begin
                        state          <= S_HDR;
                        busy           <= 1'b1;
                        word_cnt       <= '0;
                        err_inst_align <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (hs) begin
                        pe_q      <= hdr_in.pe;
                        ns_q      <= hdr_in.ns;
                        remaining <= hdr_in.len_m1;
                        last_q    <= bus.in_last;
                        phase     <= '0;
                        state     <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (hs) begin
                        wr_valid <= 1'b1;
                        wr_pe    <= pe_q;
                        wr_ns    <= ns_q;
                        wr_data  <= bus.in_data;
                        if (word_cnt != '1) begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                        // Instruction bursts must end on a packed-word boundary
                        if (ns_q == NS_INST) begin
                            phase <= phase_inc(phase);
                            if (burst_end && phase != INST_LAST) begin
                                err_inst_align <= 1'b1;
                            end
                        end
                        if (burst_end) begin
                            state <= last_q ? S_SYNC : S_HDR;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                S_SYNC: begin
                    // Final write must leave the bus before done is trusted
                    if (!wr_valid && (&pe_wrt_done)) begin
                        start <= 1'b1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (&pe_eoc) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pe_namespace_loader.md
Name: pe_namespace_loader

Overview:
- Sequencer in front of the per-PE namespace memories.
- Takes a framed word stream (header + payload bursts) from the host-side buffer.
- Drives the shared namespace write bus (valid, PE id, namespace type, data).
- Waits for every PE to report its namespace write done, issues a one-cycle start, then waits for end-of-compute from all PEs before signalling completion.

Parameters:
- logNumPe, 3, log2 of PE count; numPe = 2**logNumPe
- logMemNamespaces, 2, namespace type width (0 inst, 1 data, 2 weight, 3 meta)
- memDataLen, 16, bus/stream word width
- countLen, 11, burst length field width in header (length-1 encoding)
- instWords, 5, stream words per packed 69-bit instruction

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous active-low reset
- cfg_go  in  1  pulse: begin a load/run sequence (honoured only in IDLE)
- cfg_abort  in  1  pulse: return to IDLE from any state
- in_valid  in  1  stream word valid
- in_ready  out  1  stream word accepted when in_valid&in_ready
- in_data  in  memDataLen  header or payload word
- in_last  in  1  qualifies a header word: this burst is the final one
- mem_wrt_back  in  1  namespace bus busy with write-back; loader must not issue
- pe_wrt_done  in  numPe  per-PE namespace write done
- pe_eoc  in  numPe  per-PE end of compute
- mem_wrt_valid  out  1  namespace write strobe
- peId_mem_in  out  logNumPe  target PE
- mem_data_type  out  logMemNamespaces  target namespace
- mem_data_out  out  memDataLen  write data
- start  out  1  one-cycle PE start pulse
- done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- err_inst_align  out  1  sticky: an instruction burst length was not a multiple of instWords
- word_cnt  out  16  payload words written since cfg_go, saturating at 16'hFFFF

Behaviour:
- Reset (ARESETN=0 at ACLK edge): state IDLE; all outputs 0; counters cleared; err_inst_align cleared.
- Header word format: [15:13] peId, [12:11] type, [10:0] len-1. Header capture also latches in_last.
- States and transitions:
  - IDLE: in_ready=0; cfg_go -> HDR; word_cnt and err cleared on cfg_go.
  - HDR: in_ready=!mem_wrt_back; on handshake latch peId, type, remaining=len-1, last; instruction-word phase counter=0 -> BURST.
  - BURST: in_ready=!mem_wrt_back. Each handshake registers (1-cycle latency):
    - mem_wrt_valid=1, peId_mem_in=latched peId, mem_data_type=latched type, mem_data_out=in_data.
    - No handshake -> mem_wrt_valid=0; peId/type/data hold their last values.
    - On the handshake with remaining==0: if last -> SYNC, else -> HDR. Otherwise remaining decrements.
  - SYNC: in_ready=0; wait until &pe_wrt_done=1 (sampled in the cycle after the final write drains) -> START.
  - START: start=1 for exactly one cycle -> RUN.
  - RUN: wait &pe_eoc=1 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Instruction alignment: for type 0, the phase counter wraps at instWords-1. At burst end, if the phase after the last word != instWords-1, set err_inst_align. The burst is still written in full. Non-instruction bursts do not touch the phase counter.
- mem_wrt_back asserted mid-burst: in_ready drops the same cycle (combinational); no write issued; resume when deasserted; no word lost or duplicated.
- len-1=0: a single-word burst is legal.
- len-1=2047: 2048 words; counter must not wrap early.
- cfg_go outside IDLE: ignored.
- cfg_abort: highest priority; next cycle state=IDLE, mem_wrt_valid=0, start=0, done=0. word_cnt and err hold their values.
- Simultaneous cfg_abort and cfg_go in IDLE: abort wins (stay IDLE).
- word_cnt increments on every payload handshake; headers are not counted.
- busy=1 from the cycle after cfg_go until the cycle after done, or until abort.

Decomposition:
- Shared package holds the namespace type encodings (NS_INST=0, NS_DATA=1, NS_WEIGHT=2, NS_META=3), the header field offsets/widths, and the state encoding.
- No sub-module required. The FSM, burst counter, phase counter and output register live in one module.

Test Plan:
- Single instruction burst: header 16'h0004 (PE0, inst, 5 words, last), 5 payload words, pe_wrt_done=8'hFF → 5 mem_wrt_valid cycles each one cycle after its handshake, type 0; start 1 cycle in START; pe_eoc=8'hFF → done pulse; word_cnt=5; err_inst_align=0.
- Misaligned instruction burst: header 16'h0003 (4 words) → 4 writes, then err_inst_align=1 and stays 1 through done.
- Multi-burst: PE3 data 2 words 16'h12,16'h56, then PE5 weight 1 word 16'h34 (last) → peId/type 3/1,3/1,5/2 on the bus in order; SYNC entered only after the final write.
- Back-pressure: mem_wrt_back high for 3 cycles mid-burst → in_ready=0 and mem_wrt_valid=0 for those cycles; all words delivered exactly once.
- Partial done: pe_wrt_done=8'h7F held 10 cycles, then 8'hFF → start asserts only after the 8'hFF cycle; same check for pe_eoc before done.
- Abort in BURST after 2 of 5 words → IDLE next cycle, busy=0, word_cnt=2; a following cfg_go reruns the sequence cleanly.
